// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost flags, sticky error flags and a registered read port.
// Read latency 1 cycle (dout/dout_valid); push at full is refused unless a pop frees a slot in the same cycle.
module sync_fifo_flags #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       err_clr
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             push_ok, pop_ok;

   assign empty        = (count_q == '0);
   assign full         = (count_q == CNT_FULL);
   assign almost_full  = (count_q >= CNT_AF);
   assign almost_empty = (count_q <= CNT_AE);

   // A pop at empty is never bypassed; a push at full rides on a same-cycle pop.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      dout_d       = dout_q;
      dout_valid_d = pop_ok;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
         dout_d   = mem_q[rd_ptr_q];
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // Set beats clear so an error in the clearing cycle is not lost.
      overflow_d  = (overflow_q & ~err_clr) | (push & ~push_ok);
      underflow_d = (underflow_q & ~err_clr) | (pop & ~pop_ok);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !rst) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed vector bench for sync_fifo_flags at WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2.
module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       rst, push, pop, err_clr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       dout_valid, full, empty, almost_full, almost_empty;
   logic [3:0] count;
   logic       overflow, underflow;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      string      name;
      logic       rst, push, pop, err_clr;
      logic [7:0] din;
      int         cnt;
      logic [7:0] dout;
      logic       dv, ovf, unf;
   } vec_t;

   vec_t vq[$];

   sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
      .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
      .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   function automatic void add(string n, logic r, logic pu, logic po, logic ec,
                               logic [7:0] d, int c, logic [7:0] dq,
                               logic dv, logic ov, logic un);
      vec_t v;
      v.name = n; v.rst = r; v.push = pu; v.pop = po; v.err_clr = ec;
      v.din = d; v.cnt = c; v.dout = dq; v.dv = dv; v.ovf = ov; v.unf = un;
      vq.push_back(v);
   endfunction

   // Drive one cycle of inputs, then check every output just after the edge.
   task automatic step(input vec_t v);
      logic [18:0] exp_v, act_v;
      rst = v.rst; push = v.push; pop = v.pop; err_clr = v.err_clr; din = v.din;
      @(posedge clk);
      #1;
      exp_v = {4'(v.cnt), v.cnt == 0, v.cnt == 8, v.cnt >= 6, v.cnt <= 2,
               v.dout, v.dv, v.ovf, v.unf};
      act_v = {count, empty, full, almost_full, almost_empty,
               dout, dout_valid, overflow, underflow};
      n_vec++;
      if (act_v !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got cnt=%0d e=%b f=%b af=%b ae=%b dout=%h dv=%b ovf=%b unf=%b | want cnt=%0d e=%b f=%b af=%b ae=%b dout=%h dv=%b ovf=%b unf=%b",
                  v.name, count, empty, full, almost_full, almost_empty, dout, dout_valid, overflow, underflow,
                  v.cnt, exp_v[14], exp_v[13], exp_v[12], exp_v[11], v.dout, v.dv, v.ovf, v.unf);
      end
   endtask

   task automatic hstep(string n, logic r, logic pu, logic po, logic ec,
                        logic [7:0] d, int c, logic [7:0] dq,
                        logic dv, logic ov, logic un);
      vec_t v;
      v.name = n; v.rst = r; v.push = pu; v.pop = po; v.err_clr = ec;
      v.din = d; v.cnt = c; v.dout = dq; v.dv = dv; v.ovf = ov; v.unf = un;
      step(v);
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; din = 8'h00;

      //  name           rst pu po ec din         cnt dout        dv ovf unf
      add("reset",        1, 0, 0, 0, 8'h00,       0, 8'h00,       0, 0, 0);
      add("idle",         0, 0, 0, 0, 8'h00,       0, 8'h00,       0, 0, 0);
      for (int i = 0; i < 8; i++)
         add("fill",      0, 1, 0, 0, 8'(8'h10 + i), i + 1, 8'h00, 0, 0, 0);
      add("ovf_push",     0, 1, 0, 0, 8'hFF,       8, 8'h00,       0, 1, 0);
      add("ovf_hold",     0, 0, 0, 0, 8'h00,       8, 8'h00,       0, 1, 0);
      for (int k = 0; k < 8; k++)
         add("drain",     0, 0, 1, 0, 8'h00,   7 - k, 8'(8'h10 + k), 1, 1, 0);
      add("dv_pulse",     0, 0, 0, 0, 8'h00,       0, 8'h17,       0, 1, 0);
      add("err_clr_ovf",  0, 0, 0, 1, 8'h00,       0, 8'h17,       0, 0, 0);
      for (int i = 0; i < 8; i++)
         add("fill2",     0, 1, 0, 0, 8'(8'h20 + i), i + 1, 8'h17, 0, 0, 0);
      add("full_pushpop", 0, 1, 1, 0, 8'hAA,       8, 8'h20,       1, 0, 0);
      for (int k = 0; k < 8; k++)
         add("drain2",    0, 0, 1, 0, 8'h00,   7 - k, (k < 7) ? 8'(8'h21 + k) : 8'hAA, 1, 0, 0);
      add("pop_empty",    0, 0, 1, 0, 8'h00,       0, 8'hAA,       0, 0, 1);
      add("pushpop_empty",0, 1, 1, 0, 8'h55,       1, 8'hAA,       0, 0, 1);
      add("pop_55",       0, 0, 1, 0, 8'h00,       0, 8'h55,       1, 0, 1);
      add("clr_vs_set",   0, 0, 1, 1, 8'h00,       0, 8'h55,       0, 0, 1);
      add("clr_unf",      0, 0, 0, 1, 8'h00,       0, 8'h55,       0, 0, 0);
      for (int i = 0; i < 3; i++)
         add("wrap_prime",0, 1, 0, 0, 8'(i),   i + 1, 8'h55,       0, 0, 0);
      for (int j = 0; j < 20; j++)
         add("wrap",      0, 1, 1, 0, 8'(3 + j),   3, 8'(j),       1, 0, 0);
      add("ae_rise",      0, 0, 1, 0, 8'h00,       2, 8'h14,       1, 0, 0);
      add("ae_fall",      0, 1, 0, 0, 8'h30,       3, 8'h14,       0, 0, 0);

      foreach (vq[i]) step(vq[i]);

      // Drain, set underflow, refill to 5, then reset with a push pending.
      hstep("pre_pop_a",   0, 0, 1, 0, 8'h00, 2, 8'h15, 1, 0, 0);
      hstep("pre_pop_b",   0, 0, 1, 0, 8'h00, 1, 8'h16, 1, 0, 0);
      hstep("pre_pop_c",   0, 0, 1, 0, 8'h00, 0, 8'h30, 1, 0, 0);
      hstep("pre_unf",     0, 0, 1, 0, 8'h00, 0, 8'h30, 0, 0, 1);
      for (int i = 0; i < 5; i++)
         hstep("pre_fill", 0, 1, 0, 0, 8'(8'h40 + i), i + 1, 8'h30, 0, 0, 1);
      hstep("rst_with_push", 1, 1, 0, 0, 8'hEE, 0, 8'h00, 0, 0, 0);
      hstep("push_dropped",  0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
      hstep("rst_with_pop",  1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
      hstep("post_push",     0, 1, 0, 0, 8'h61, 1, 8'h00, 0, 0, 0);
      hstep("post_pop",      0, 0, 1, 0, 8'h00, 0, 8'h61, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8x8 circular-buffer FIFO.
- Adds generic width and depth, an occupancy count, programmable almost-full/almost-empty flags and a registered read port with a valid strobe.
- Adds sticky overflow/underflow error flags and defined simultaneous push/pop behaviour at the full and empty boundaries.
- Sits between producer/consumer datapaths (UART/ALU/register-file stages) wherever elastic buffering is needed.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of storage entries (>=2; need not be a power of two).
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- push  in  1  write request.
- din  in  WIDTH  write data, sampled with push.
- pop  in  1  read request.
- dout  out  WIDTH  read data, registered.
- dout_valid  out  1  high for one cycle when dout carries a newly popped word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky; push refused at least once.
- underflow  out  1  sticky; pop refused at least once.
- err_clr  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_ptr, rd_ptr and count go to 0.
  - dout=0, dout_valid=0, overflow=0, underflow=0.
  - Storage contents are not cleared.
  - rst overrides all other inputs in that cycle. A push/pop coincident with rst is discarded and does not set error flags.
- Flags are combinational from count, valid the cycle after any update. After reset: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
- Pop acceptance:
  - pop_ok = pop & !empty.
  - Accepted pop: the word at rd_ptr is registered into dout at the edge; dout_valid=1 in the following cycle.
  - Read latency is 1 cycle. dout holds its last value when no pop is accepted. dout_valid is a single-cycle pulse per accepted pop.
- Push acceptance:
  - push_ok = push & (!full | pop_ok).
  - Push at full with a simultaneous valid pop is accepted: the read occurs from the old rd_ptr and the write goes to the freed slot. count stays DEPTH.
  - Push at empty with simultaneous pop: the pop is refused (no bypass), the push is accepted, count becomes 1, and underflow is set.
- Pointers:
  - Each pointer advances by 1 on accept and wraps from DEPTH-1 to 0. Explicit compare is used, not power-of-two masking.
- Count update:
  - +1 on push_ok only.
  - -1 on pop_ok only.
  - Unchanged when both or neither are accepted.
  - Never exceeds DEPTH, never goes below 0.
- Error flags:
  - overflow is set when push & !push_ok.
  - underflow is set when pop & !pop_ok.
  - Both hold until err_clr or rst.
  - If err_clr and a new error occur in the same cycle, set wins (flag = 1).
- Rejected operations change no pointer, count, storage or dout.
- Ordering: strict FIFO; data is returned in push order across any number of wraps.

Test Plan (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2):
- Reset then idle:
  - empty=1, full=0, count=0, almost_empty=1, almost_full=0, dout=0, dout_valid=0, overflow=underflow=0.
- Push 0x10..0x17 (8 words), then one extra push of 0xFF:
  - almost_full rises when count=6; full=1 at count=8.
  - Extra push is refused; overflow=1 and stays 1.
  - Popping 8 times yields dout 0x10..0x17, each one cycle after its pop with dout_valid=1.
  - Then empty=1.
- At full (count=8), assert push(0xAA) and pop together:
  - count stays 8; dout=oldest word.
  - After 8 further pops, the last word out is 0xAA.
- At empty, assert pop alone, then push(0x55)+pop together:
  - underflow=1 after the first; dout and dout_valid unchanged.
  - Second cycle: count=1, underflow still 1.
  - Next pop returns 0x55.
- Wrap stress: 20 cycles of interleaved push/pop holding count at 3, with data incrementing from 0x00:
  - Output stream is 0x00,0x01,... with no gaps or repeats across pointer wrap.
  - almost_empty toggles correctly around count 2/3.
- Assert rst mid-operation at count=5 with push=1:
  - Next cycle count=0, empty=1, dout_valid=0.
  - The push is discarded; error flags are cleared.
  - err_clr alone clears a previously set overflow.
